async_fifo: RTL and testbench

- Parameterized FIFO buffer with registered storage and full/empty status flags.
- Sits between a data producer and a consumer inside the system and decouples their bursts.
- This implementation uses one clock for both the write and read sides; reset is synchronous.
- Pointers use an extra wrap bit, so full and empty are distinguished without a counter.

---
 rtl/async_fifo.sv | 53 +++++
 tb/tb_async_fifo.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/async_fifo.sv
// Single-clock FIFO with registered storage and wrap-bit pointers.
// RD_DATA is first-word fall-through; FULL/EMPTY decode directly from the pointers.
module async_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic                  R_INC,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  FULL,
  output logic                  EMPTY
);

  localparam int ADDR_WIDTH = PTR_WIDTH - 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wptr;
  logic [PTR_WIDTH-1:0]  rptr;
  logic                  do_write;
  logic                  do_read;

  assign do_write = W_INC && !FULL;
  assign do_read  = R_INC && !EMPTY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
      mem  <= '{default: '0};
    end else begin
      if (do_write) begin
        mem[wptr[ADDR_WIDTH-1:0]] <= WR_DATA;
        wptr                      <= wptr + 1'b1;
      end
      if (do_read) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  // Equal addresses mean empty when the wrap bits agree, full when they differ.
  always_comb begin
    EMPTY   = (wptr == rptr);
    FULL    = (wptr[PTR_WIDTH-1] != rptr[PTR_WIDTH-1]) &&
              (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    RD_DATA = mem[rptr[ADDR_WIDTH-1:0]];
  end

endmodule

// File: tb/tb_async_fifo.sv
// Randomized bench for async_fifo against a queue-based reference model.
module tb_async_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          w_inc;
  logic          r_inc;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          full;
  logic          empty;

  async_fifo #(
    .DATA_WIDTH(DW),
    .PTR_WIDTH (4),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .W_INC  (w_inc),
    .R_INC  (r_inc),
    .WR_DATA(wr_data),
    .RD_DATA(rd_data),
    .FULL   (full),
    .EMPTY  (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [DW-1:0] model_q[$];
  bit            clean_since_reset = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // One clock cycle: drive, advance the model at the edge, compare at the falling edge.
  task automatic step(input bit rst_i, input bit w, input bit r, input logic [DW-1:0] d);
    bit was_full;
    bit was_empty;
    rst     = rst_i;
    w_inc   = w;
    r_inc   = r;
    wr_data = d;
    @(posedge clk);
    if (rst_i) begin
      model_q.delete();
      clean_since_reset = 1'b1;
    end else begin
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      if (r && !was_empty) void'(model_q.pop_front());
      if (w && !was_full) begin
        model_q.push_back(d);
        clean_since_reset = 1'b0;
      end
    end
    @(negedge clk);
    check("empty", {31'd0, empty}, {31'd0, model_q.size() == 0});
    check("full",  {31'd0, full},  {31'd0, model_q.size() == DEPTH});
    if (model_q.size() != 0)
      check("rd_data", {24'd0, rd_data}, {24'd0, model_q[0]});
    else if (clean_since_reset)
      check("rd_data_rst", {24'd0, rd_data}, 32'd0);
  endtask

  logic [DW-1:0] a [9];

  initial begin
    rst = 1'b1; w_inc = 1'b0; r_inc = 1'b0; wr_data = '0;
    @(negedge clk);

    // Reset with requests pulsed: both must be ignored.
    step(1, 1, 1, 8'hFF);
    step(1, 1, 0, 8'h11);
    step(0, 0, 0, 8'h00);

    // Overfill: ninth word dropped, head stays A0.
    for (int i = 0; i < 9; i++) begin
      a[i] = 8'($urandom);
      step(0, 1, 0, a[i]);
      check("ovf_head", {24'd0, rd_data}, {24'd0, a[0]});
      check("ovf_full", {31'd0, full}, {31'd0, i >= 7});
    end

    // Drain: A0..A7 in order, ninth pop ignored.
    for (int i = 0; i < 9; i++) begin
      if (i < 8) check("drain_order", {24'd0, rd_data}, {24'd0, a[i]});
      step(0, 0, 1, 8'h00);
      check("drain_empty", {31'd0, empty}, {31'd0, i >= 7});
    end

    // Simultaneous push/pop with 3 stored.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'($urandom));
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 8'($urandom));
      check("sim_occ", model_q.size(), 32'd3);
    end

    // Both asserted while full: read only.
    while (model_q.size() < DEPTH) step(0, 1, 0, 8'($urandom));
    step(0, 1, 1, 8'hC3);
    check("full_both", {31'd0, full}, 32'd0);

    // Both asserted while empty: write only.
    while (model_q.size() > 0) step(0, 0, 1, 8'h00);
    step(0, 1, 1, 8'h3C);
    check("empty_both", {31'd0, empty}, 32'd0);
    check("empty_both_data", {24'd0, rd_data}, 32'h3C);
    step(0, 0, 1, 8'h00);

    // Wrap-around: 20 words in bursts of 5.
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 5; i++) step(0, 1, 0, 8'($urandom));
      for (int i = 0; i < 5; i++) step(0, 0, 1, 8'h00);
    end

    // Reset mid-operation.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'($urandom));
    step(1, 0, 0, 8'h00);
    check("mid_rst_data", {24'd0, rd_data}, 32'd0);
    step(0, 1, 0, 8'h5A);
    check("post_rst_data", {24'd0, rd_data}, 32'h5A);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 63) == 0, 1'($urandom), 1'($urandom), 8'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
